// File: rtl/draw_line_fb.sv
`default_nettype none
// ============================================================================
//  Module   : draw_line_fb
//  Purpose  : Bresenham line rasteriser that emits one framebuffer write
//             (enable, linear address, colour) per pixel. Handles any octant
//             and signed endpoints; oe stalls drawing without losing a pixel.
//  Options  : define DRAW_LINE_FB_CLIP_EN to suppress writes for pixels that
//             fall outside the FB_WIDTH x FB_HEIGHT framebuffer.
//  Revision : 1.0  initial release
// ============================================================================
module draw_line_fb #(
  parameter int CORDW     = 16,
  parameter int FB_WIDTH  = 160,
  parameter int FB_HEIGHT = 120,
  parameter int FB_DATAW  = 1,
  parameter int FB_ADDRW  = $clog2(FB_WIDTH*FB_HEIGHT)
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
  input  logic                       oe,
  input  logic signed [CORDW-1:0]    x0,
  input  logic signed [CORDW-1:0]    y0,
  input  logic signed [CORDW-1:0]    x1,
  input  logic signed [CORDW-1:0]    y1,
  input  logic        [FB_DATAW-1:0] colr,
  output logic signed [CORDW-1:0]    x,
  output logic signed [CORDW-1:0]    y,
  output logic                       fb_we,
  output logic        [FB_ADDRW-1:0] fb_addr,
  output logic        [FB_DATAW-1:0] fb_colr,
  output logic                       busy,
  output logic                       done
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_INIT = 2'd1,
    S_DRAW = 2'd2,
    S_DONE = 2'd3
  } state_t;

  localparam logic signed [CORDW-1:0] c_one  = CORDW'(1);
`ifdef DRAW_LINE_FB_CLIP_EN
  localparam logic signed [CORDW-1:0] c_fb_w = CORDW'(FB_WIDTH);
  localparam logic signed [CORDW-1:0] c_fb_h = CORDW'(FB_HEIGHT);
`endif

  state_t                   r_state;
  logic signed [CORDW-1:0]  r_x0, r_y0, r_x1, r_y1;
  logic signed [CORDW-1:0]  r_px, r_py;           // pixel to be emitted next
  logic signed [CORDW+1:0]  r_dx, r_dy, r_err;    // r_dy is stored negated
  logic                     r_sx_neg, r_sy_neg;

  // Endpoints widened by two bits so differences and 2*err never overflow.
  logic signed [CORDW+1:0]  w_x0e, w_y0e, w_x1e, w_y1e;
  logic signed [CORDW+1:0]  w_dxr, w_dyr, w_dx, w_dy;
  logic signed [CORDW+1:0]  w_e2, w_err_next;
  logic                     w_step_x, w_step_y, w_last;
  logic signed [CORDW-1:0]  w_px_next, w_py_next;
  logic        [FB_ADDRW-1:0] w_addr;
`ifdef DRAW_LINE_FB_CLIP_EN
  logic                     w_onscreen;
`endif

  assign w_x0e = {{2{r_x0[CORDW-1]}}, r_x0};
  assign w_y0e = {{2{r_y0[CORDW-1]}}, r_y0};
  assign w_x1e = {{2{r_x1[CORDW-1]}}, r_x1};
  assign w_y1e = {{2{r_y1[CORDW-1]}}, r_y1};

  assign w_dxr = w_x1e - w_x0e;
  assign w_dyr = w_y1e - w_y0e;
  assign w_dx  = w_dxr[CORDW+1] ? -w_dxr : w_dxr;   //  |x1-x0|
  assign w_dy  = w_dyr[CORDW+1] ? w_dyr : -w_dyr;   // -|y1-y0|

  // Both step decisions look at the same e2, so a diagonal move takes one cycle.
  assign w_e2       = {r_err[CORDW:0], 1'b0};
  assign w_step_x   = (w_e2 >= r_dy);
  assign w_step_y   = (w_e2 <= r_dx);
  assign w_err_next = r_err + (w_step_x ? r_dy : {(CORDW+2){1'b0}})
                            + (w_step_y ? r_dx : {(CORDW+2){1'b0}});
  assign w_px_next  = w_step_x ? (r_sx_neg ? r_px - c_one : r_px + c_one) : r_px;
  assign w_py_next  = w_step_y ? (r_sy_neg ? r_py - c_one : r_py + c_one) : r_py;
  assign w_last     = (r_px == r_x1) && (r_py == r_y1);

  // Address is formed from the pixel being registered onto x/y this cycle,
  // so fb_addr, x, y and fb_we always describe the same pixel.
  assign w_addr = FB_ADDRW'(FB_ADDRW'(r_py) * FB_ADDRW'(FB_WIDTH) + FB_ADDRW'(r_px));

`ifdef DRAW_LINE_FB_CLIP_EN
  assign w_onscreen = !r_px[CORDW-1] && !r_py[CORDW-1] &&
                      (r_px < c_fb_w) && (r_py < c_fb_h);
`endif

  // Control FSM with registered outputs; one pixel per enabled DRAW cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_x0     <= '0;
      r_y0     <= '0;
      r_x1     <= '0;
      r_y1     <= '0;
      r_px     <= '0;
      r_py     <= '0;
      r_dx     <= '0;
      r_dy     <= '0;
      r_err    <= '0;
      r_sx_neg <= 1'b0;
      r_sy_neg <= 1'b0;
      x        <= '0;
      y        <= '0;
      fb_we    <= 1'b0;
      fb_addr  <= '0;
      fb_colr  <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      fb_we <= 1'b0;
      done  <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_x0    <= x0;
            r_y0    <= y0;
            r_x1    <= x1;
            r_y1    <= y1;
            fb_colr <= colr;
            busy    <= 1'b1;
            r_state <= S_INIT;
          end
        end
        S_INIT: begin
          r_dx     <= w_dx;
          r_dy     <= w_dy;
          r_err    <= w_dx + w_dy;
          r_sx_neg <= w_dxr[CORDW+1];
          r_sy_neg <= w_dyr[CORDW+1];
          r_px     <= r_x0;
          r_py     <= r_y0;
          r_state  <= S_DRAW;
        end
        S_DRAW: begin
          if (oe) begin
            x <= r_px;
            y <= r_py;
`ifdef DRAW_LINE_FB_CLIP_EN
            if (w_onscreen) begin
              fb_we   <= 1'b1;
              fb_addr <= w_addr;
            end
`else
            fb_we   <= 1'b1;
            fb_addr <= w_addr;
`endif
            r_px  <= w_px_next;
            r_py  <= w_py_next;
            r_err <= w_err_next;
            if (w_last) begin
              r_state <= S_DONE;
            end
          end
        end
        S_DONE: begin
          done    <= 1'b1;
          busy    <= 1'b0;
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire
